alu_seq: RTL
============

Name: alu_seq

Overview:
- Parametrised N-bit ALU built from the 1-bit slice concept (AND/OR/ADD/SUB/SLT/NOR via A_invert/B_invert/carry-in).
- Extended with a multi-cycle shift-add multiplier, registered outputs, status flags and a valid/ready handshake on both sides.
- Sits between decode/operand fetch and writeback in the multi-cycle datapath.
- The pipeline stalls on in_ready/out_valid rather than assuming single-cycle results.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4).
- CNT_W, $clog2(WIDTH)+1, multiply iteration counter width.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous active-low reset.
- in_valid_i  input  1  operands and ctrl valid this cycle.
- in_ready_o  output  1  block accepts a new operation.
- src1_i  input  WIDTH  operand A.
- src2_i  input  WIDTH  operand B.
- ctrl_i  input  4  operation select (see Behaviour).
- out_valid_o  output  1  result/flags valid.
- out_ready_i  input  1  consumer takes result.
- result_o  output  WIDTH  registered result.
- zero_o  output  1  result_o == 0.
- cout_o  output  1  adder carry-out (ADD/SUB/SLT), else 0.
- overflow_o  output  1  signed overflow (ADD/SUB), else 0.

Behaviour:
- ctrl encoding:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB (B_invert=1, cin=1)
  - 0111 SLT (signed; result = {0..0, sign(A-B) XOR overflow})
  - 1100 NOR (A_invert=B_invert=1, AND)
  - 1000 MUL (low WIDTH bits of unsigned A*B)
  - Any other code: result 0, flags 0, latency 1.
- Reset (rst_i low, async): state=IDLE, out_valid_o=0, result_o=0, zero_o=0, cout_o=0, overflow_o=0, counter=0. in_ready_o reads 1 once reset is released.
- FSM states:
  - IDLE: accept when in_valid_i & in_ready_o.
    - Non-MUL op: result and flags registered the same edge → DONE. Latency 1 cycle.
    - MUL op: load multiplicand=src1, multiplier=src2, acc=0, cnt=WIDTH → MUL.
  - MUL: each cycle, if multiplier[0] then acc += multiplicand (mod 2^WIDTH); multiplicand <<= 1; multiplier >>= 1; cnt--.
    - When cnt reaches 0, register acc to result_o → DONE.
    - Latency is WIDTH+1 edges after acceptance. Early termination is not permitted (fixed latency).
  - DONE: out_valid_o=1.
    - On out_ready_i=1 → IDLE.
    - If in_valid_i is also high that edge, the new op is accepted back-to-back (see in_ready).
- in_ready_o = (state==IDLE) | (state==DONE & out_ready_i). Combinational from out_ready_i only, no path from in_valid_i.
- Outputs hold stable while out_valid_o=1 & out_ready_i=0. Inputs are sampled only at acceptance; src/ctrl changes afterwards have no effect.
- Flags:
  - zero_o is computed from the registered result.
  - MUL: cout_o=0, overflow_o=0.
  - overflow = carry into MSB XOR carry out of MSB, for ADD/SUB only.
- Back-to-back throughput: one non-MUL op per cycle when out_ready_i is held high.
- Async reset asserted mid-MUL aborts the operation. No partial result is ever presented.

Decomposition:
- Package alu_pkg:
  - ctrl localparams: ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR, ALU_MUL.
  - state encoding: IDLE, MUL, DONE.
- Sub-module alu_comb: purely combinational WIDTH-bit AND/OR/ADD/SUB/SLT/NOR with cout/overflow, built from A_invert/B_invert/cin control.
- alu_seq owns the FSM, multiplier datapath, output registers and handshake.

Test Plan (WIDTH=32):
- Reset: hold rst_i=0 mid-MUL, release → out_valid_o=0, result_o=0, in_ready_o=1.
- ADD 0x7FFFFFFF+1 → result 0x80000000, overflow_o=1, cout_o=0, zero_o=0, out_valid_o one cycle after accept.
- SUB 5-5 → result 0, zero_o=1, cout_o=1. SLT 0xFFFFFFFF(-1) vs 1 → result 1. NOR 0,0 → 0xFFFFFFFF.
- MUL 0x0001_0003 * 0x0000_0005 → 0x0005_000F after exactly 33 edges; in_ready_o=0 throughout MUL.
- Backpressure: out_ready_i=0 for 4 cycles after a result → result_o/flags stable, in_ready_o=0. Then out_ready_i=1 with in_valid_i=1 (OR 0xF0,0x0F) → new op accepted the same edge, result 0xFF next cycle.
- Streaming: 8 ADDs with out_ready_i=1 → 8 results on 8 consecutive cycles. Undefined ctrl 1111 → result 0, flags 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: operation codes, FSM states and
// small decode helpers used by both the datapath and the control block.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_MUL = 4'b1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Single-cycle operations handled by the slice-style combinational ALU.
    function automatic logic is_comb_op(input logic [3:0] ctrl);
        return (ctrl == ALU_AND) || (ctrl == ALU_OR)  || (ctrl == ALU_ADD) ||
               (ctrl == ALU_SUB) || (ctrl == ALU_SLT) || (ctrl == ALU_NOR);
    endfunction

    function automatic logic has_carry(input logic [3:0] ctrl);
        return (ctrl == ALU_ADD) || (ctrl == ALU_SUB) || (ctrl == ALU_SLT);
    endfunction

    function automatic logic has_overflow(input logic [3:0] ctrl);
        return (ctrl == ALU_ADD) || (ctrl == ALU_SUB);
    endfunction

endpackage

// File: rtl/alu_comb.sv
// Combinational WIDTH-bit ALU assembled from 1-bit slices controlled by
// A_invert (ctrl[3]), B_invert (ctrl[2], also the carry-in) and op (ctrl[1:0]).
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       ctrl,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    logic             a_invert;
    logic             b_invert;
    logic [1:0]       op;
    logic [WIDTH-1:0] aa;
    logic [WIDTH-1:0] bb;
    logic [WIDTH-1:0] sum;
    logic [WIDTH:0]   carry;
    logic             set;

    assign a_invert = ctrl[3];
    assign b_invert = ctrl[2];
    assign op       = ctrl[1:0];

    // Ripple chain: each slice produces its sum bit and the carry into the next.
    always_comb begin
        aa       = a_invert ? ~a : a;
        bb       = b_invert ? ~b : b;
        sum      = '0;
        carry    = '0;
        carry[0] = b_invert;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i]     = aa[i] ^ bb[i] ^ carry[i];
            carry[i+1] = (aa[i] & bb[i]) | (aa[i] & carry[i]) | (bb[i] & carry[i]);
        end
        cout     = carry[WIDTH];
        overflow = carry[WIDTH] ^ carry[WIDTH-1];
        // The MSB slice's set output: sign of A-B corrected for overflow.
        set      = sum[WIDTH-1] ^ overflow;
    end

    always_comb begin
        result = '0;
        case (op)
            2'b00:   result = aa & bb;
            2'b01:   result = aa | bb;
            2'b10:   result = sum;
            default: result = {{(WIDTH-1){1'b0}}, set};
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU stage: single-cycle logic/arith ops, a fixed-latency
// shift-add multiplier, registered result and flags, valid/ready on both sides.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [3:0]       ctrl_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             cout_o,
    output logic             overflow_o,
    output logic [1:0]       state_o
);

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] alu_res;
    logic             alu_cout;
    logic             alu_ovf;

    logic [WIDTH-1:0] op_res;
    logic             op_zero;
    logic             op_cout;
    logic             op_ovf;
    logic             accept;

    alu_comb #(
        .WIDTH (WIDTH)
    ) u_comb (
        .a        (src1_i),
        .b        (src2_i),
        .ctrl     (ctrl_i),
        .result   (alu_res),
        .cout     (alu_cout),
        .overflow (alu_ovf)
    );

    // Handshake: a transfer happens on a rising edge where valid & ready are
    // both high. in_ready depends on state and out_ready_i only, never on
    // in_valid_i; out_valid and the result/flags hold until out_ready_i.
    assign in_ready_o  = (state == IDLE) || ((state == DONE) && out_ready_i);
    assign out_valid_o = (state == DONE);
    assign accept      = in_valid_i && in_ready_o;
    assign state_o     = state;

    assign acc_next = acc + (mplier[0] ? mcand : '0);

    // Undefined codes yield an all-zero result with every flag, zero_o included, low.
    always_comb begin
        op_res  = '0;
        op_zero = 1'b0;
        op_cout = 1'b0;
        op_ovf  = 1'b0;
        if (is_comb_op(ctrl_i)) begin
            op_res  = alu_res;
            op_zero = (alu_res == '0);
            op_cout = has_carry(ctrl_i) ? alu_cout : 1'b0;
            op_ovf  = has_overflow(ctrl_i) ? alu_ovf : 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= IDLE;
            mcand      <= '0;
            mplier     <= '0;
            acc        <= '0;
            cnt        <= '0;
            result_o   <= '0;
            zero_o     <= 1'b0;
            cout_o     <= 1'b0;
            overflow_o <= 1'b0;
        end else if (accept) begin
            if (ctrl_i == ALU_MUL) begin
                mcand  <= src1_i;
                mplier <= src2_i;
                acc    <= '0;
                cnt    <= CNT_W'(WIDTH);
                state  <= MUL;
            end else begin
                result_o   <= op_res;
                zero_o     <= op_zero;
                cout_o     <= op_cout;
                overflow_o <= op_ovf;
                state      <= DONE;
            end
        end else begin
            case (state)
                MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CNT_W'(1);
                    // Always runs the full WIDTH iterations so latency is fixed.
                    if (cnt == CNT_W'(1)) begin
                        result_o   <= acc_next;
                        zero_o     <= (acc_next == '0);
                        cout_o     <= 1'b0;
                        overflow_o <= 1'b0;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
